// File: rtl/bn_act_seq.sv
// bn_act_seq: applies per-channel fixed-point batch-norm and an activation to a full frame.
// LANES elements go in per cycle through a two-stage pipeline; valid_out pulses when the frame is complete.
module bn_act_seq #(
  parameter int HEIGHT     = 112,
  parameter int WIDTH      = 112,
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int LANES      = 4,
  parameter int ACT_MODE   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic signed [DATA_WIDTH-1:0] data_in  [HEIGHT][WIDTH][CHANNELS],
  input  logic signed [DATA_WIDTH-1:0] scale    [CHANNELS],
  input  logic signed [DATA_WIDTH-1:0] shift    [CHANNELS],
  output logic signed [DATA_WIDTH-1:0] data_out [HEIGHT][WIDTH][CHANNELS],
  output logic                         valid_out,
  output logic                         busy,
  output logic                         overrun
);

  localparam int N   = HEIGHT * WIDTH * CHANNELS;
  localparam int K   = (N + LANES - 1) / LANES;
  localparam int GW  = $clog2(K + 1);
  localparam int IW  = $clog2(K * LANES + 1);
  localparam int NIW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int ZW  = PW + 1;
  localparam int HW  = PW + 4;

  localparam int DMAX = 2 ** (DATA_WIDTH - 1) - 1;
  localparam int DMIN = -(2 ** (DATA_WIDTH - 1));
  localparam logic signed [DATA_WIDTH-1:0] D_MAX  = DATA_WIDTH'(DMAX);
  localparam logic signed [DATA_WIDTH-1:0] D_MIN  = DATA_WIDTH'(DMIN);
  localparam logic signed [ZW-1:0]         Z_MAX  = ZW'(DMAX);
  localparam logic signed [ZW-1:0]         Z_MIN  = ZW'(DMIN);
  localparam logic signed [HW-1:0]         H_MAX  = HW'(DMAX);
  localparam logic signed [HW-1:0]         H_MIN  = HW'(DMIN);
  localparam logic signed [HW-1:0]         H_ZERO = '0;
  localparam logic signed [HW-1:0]         ONE3   = HW'(3 << FRAC_BITS);
  localparam logic signed [HW-1:0]         ONE6   = HW'(6 << FRAC_BITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Product rescaled by an arithmetic (floor) shift, offset added, then saturated to the data range.
  function automatic logic signed [DATA_WIDTH-1:0] bn_sat(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] s,
    input logic signed [DATA_WIDTH-1:0] sh
  );
    logic signed [PW-1:0] m;
    logic signed [ZW-1:0] z;
    m = PW'(x) * PW'(s);
    z = ZW'(m >>> FRAC_BITS) + ZW'(sh);
    if (z > Z_MAX) return D_MAX;
    if (z < Z_MIN) return D_MIN;
    return z[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] y);
    logic signed [HW-1:0] yw, t, q;
    if (ACT_MODE == 1) return y[DATA_WIDTH-1] ? '0 : y;
    if (ACT_MODE == 2) begin
      yw = HW'(y);
      t  = yw + ONE3;
      if (t < H_ZERO)   t = H_ZERO;
      else if (t > ONE6) t = ONE6;
      q = (yw * t) / ONE6;
      if (q > H_MAX) return D_MAX;
      if (q < H_MIN) return D_MIN;
      return q[DATA_WIDTH-1:0];
    end
    return y;
  endfunction

  logic [0:0]                   state;
  logic [GW-1:0]                grp;
  logic [IW-1:0]                base;
  logic signed [DATA_WIDTH-1:0] x_flat   [N];
  logic signed [DATA_WIDTH-1:0] out_q    [N];
  logic [IW-1:0]                lane_idx [LANES];
  logic [CW-1:0]                lane_ch  [LANES];
  logic [LANES-1:0]             lane_act;
  logic signed [DATA_WIDTH-1:0] lane_y   [LANES];
  logic [LANES-1:0]             s1_vld;
  logic [NIW-1:0]               s1_idx   [LANES];
  logic signed [DATA_WIDTH-1:0] s1_y     [LANES];

  // Flat views: linear index runs channel fastest, then column, then row.
  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar w = 0; w < WIDTH; w++) begin : g_col
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam int IDX = (r * WIDTH + w) * CHANNELS + c;
        assign x_flat[IDX]       = data_in[r][w][c];
        assign data_out[r][w][c] = out_q[IDX];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = base + IW'(l);
      lane_act[l] = lane_idx[l] < IW'(N);
      lane_ch[l]  = CW'(lane_idx[l] % IW'(CHANNELS));
      lane_y[l]   = bn_sat(x_flat[lane_act[l] ? lane_idx[l][NIW-1:0] : '0],
                           scale[lane_ch[l]], shift[lane_ch[l]]);
    end
  end

  // Once the last group has been issued (grp == K), one drain cycle lets it retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grp       <= '0;
      base      <= '0;
      ready_in  <= 1'b1;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
      s1_vld    <= '0;
    end else begin
      valid_out <= 1'b0;
      overrun   <= valid_in & ~ready_in;
      s1_vld    <= '0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            state    <= RUN;
            grp      <= '0;
            base     <= '0;
            ready_in <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (grp != GW'(K)) begin
            s1_vld <= lane_act;
            grp    <= grp + GW'(1);
            base   <= base + IW'(LANES);
          end else begin
            state     <= IDLE;
            ready_in  <= 1'b1;
            busy      <= 1'b0;
            valid_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: stage-1 payload has no reset; s1_vld alone decides whether it is consumed.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      s1_y[l]   <= lane_y[l];
      s1_idx[l] <= lane_idx[l][NIW-1:0];
    end
  end

  // The result map must read all-zero immediately on reset, so this storage is reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) out_q[n] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (s1_vld[l]) out_q[s1_idx[l]] <= act(s1_y[l]);
      end
    end
  end

endmodule

// File: tb/tb_bn_act_seq.sv
// tb_bn_act_seq: four bn_act_seq instances (identity, ReLU, hardswish x4 lanes, hardswish x5 lanes)
// share stimulus; a scoreboard of model results is checked whenever valid_out fires.
module tb_bn_act_seq;
  localparam int H   = 2;
  localparam int W   = 2;
  localparam int C   = 3;
  localparam int DW  = 8;
  localparam int FB  = 4;
  localparam int N   = H * W * C;
  localparam int K   = 3;
  localparam int NI  = 4;
  localparam int ONE = 1 << FB;
  localparam int ALL = (1 << NI) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic signed [DW-1:0] din   [H][W][C];
  logic signed [DW-1:0] scale [C];
  logic signed [DW-1:0] shift [C];
  logic signed [DW-1:0] dout0 [H][W][C];
  logic signed [DW-1:0] dout1 [H][W][C];
  logic signed [DW-1:0] dout2 [H][W][C];
  logic signed [DW-1:0] dout3 [H][W][C];
  logic [NI-1:0] rdy, vo, bsy, ovr;

  bn_act_seq #(.HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_WIDTH(DW), .FRAC_BITS(FB),
               .LANES(4), .ACT_MODE(0)) u_id (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy[0]), .data_in(din),
    .scale(scale), .shift(shift), .data_out(dout0), .valid_out(vo[0]), .busy(bsy[0]),
    .overrun(ovr[0]));
  bn_act_seq #(.HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_WIDTH(DW), .FRAC_BITS(FB),
               .LANES(4), .ACT_MODE(1)) u_relu (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy[1]), .data_in(din),
    .scale(scale), .shift(shift), .data_out(dout1), .valid_out(vo[1]), .busy(bsy[1]),
    .overrun(ovr[1]));
  bn_act_seq #(.HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_WIDTH(DW), .FRAC_BITS(FB),
               .LANES(4), .ACT_MODE(2)) u_hs4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy[2]), .data_in(din),
    .scale(scale), .shift(shift), .data_out(dout2), .valid_out(vo[2]), .busy(bsy[2]),
    .overrun(ovr[2]));
  bn_act_seq #(.HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_WIDTH(DW), .FRAC_BITS(FB),
               .LANES(5), .ACT_MODE(2)) u_hs5 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy[3]), .data_in(din),
    .scale(scale), .shift(shift), .data_out(dout3), .valid_out(vo[3]), .busy(bsy[3]),
    .overrun(ovr[3]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int due_q [$];
  int val_q [$];
  int cur_x [N];
  int cur_s [C];
  int cur_sh [C];

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    end
  endtask

  function automatic int mode_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model(input int mode, input int x, input int s, input int sh);
    int y, t;
    y = sat(floor_div(x * s, ONE) + sh);
    if (mode == 0) return y;
    if (mode == 1) return (y < 0) ? 0 : y;
    t = y + 3 * ONE;
    if (t < 0) t = 0;
    if (t > 6 * ONE) t = 6 * ONE;
    return sat((y * t) / (6 * ONE));
  endfunction

  function automatic int out_val(input int k, input int n);
    int r, w, c;
    r = n / (W * C);
    w = (n / C) % W;
    c = n % C;
    case (k)
      0:       return int'(dout0[r][w][c]);
      1:       return int'(dout1[r][w][c]);
      2:       return int'(dout2[r][w][c]);
      default: return int'(dout3[r][w][c]);
    endcase
  endfunction

  task automatic apply();
    for (int n = 0; n < N; n++) din[n / (W * C)][(n / C) % W][n % C] = DW'(cur_x[n]);
    for (int c = 0; c < C; c++) begin
      scale[c] = DW'(cur_s[c]);
      shift[c] = DW'(cur_sh[c]);
    end
  endtask

  task automatic randomize_frame();
    for (int n = 0; n < N; n++) cur_x[n] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < C; c++) begin
      cur_s[c]  = int'($urandom_range(0, 255)) - 128;
      cur_sh[c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Called at a falling edge; the next rising edge is the acceptance edge.
  task automatic start();
    check("ready_in before start", int'(rdy), ALL);
    apply();
    valid_in = 1'b1;
    due_q.push_back(cyc + 1 + K + 1);
    for (int k = 0; k < NI; k++)
      for (int n = 0; n < N; n++)
        val_q.push_back(model(mode_of(k), cur_x[n], cur_s[n % C], cur_sh[n % C]));
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && due_q.size() != 0; t++) @(negedge clk);
    if (due_q.size() != 0) begin
      check("frame completion timeout", due_q.size(), 0);
      due_q.delete();
      val_q.delete();
    end
  endtask

  task automatic wait_vo();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = vo[0];
    end
    if (!seen) check("valid_out wait timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s u%0d ready_in", tag, k), int'(rdy[k]), 1);
      check($sformatf("%s u%0d busy", tag, k), int'(bsy[k]), 0);
      check($sformatf("%s u%0d valid_out", tag, k), int'(vo[k]), 0);
      check($sformatf("%s u%0d overrun", tag, k), int'(ovr[k]), 0);
      for (int n = 0; n < N; n++)
        check($sformatf("%s u%0d data_out[%0d]", tag, k, n), out_val(k, n), 0);
    end
  endtask

  // Monitor: every valid_out must match the oldest queued frame in timing and content.
  always @(negedge clk) begin
    if (!rst && vo != '0) begin
      if (due_q.size() == 0) begin
        check("unexpected valid_out", int'(vo), 0);
      end else begin
        check("valid_out edge", cyc, due_q.pop_front());
        for (int k = 0; k < NI; k++) begin
          check($sformatf("u%0d valid_out", k), int'(vo[k]), 1);
          for (int n = 0; n < N; n++)
            check($sformatf("u%0d data_out[%0d]", k, n), out_val(k, n), val_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int n = 0; n < N; n++) cur_x[n] = 0;
    for (int c = 0; c < C; c++) begin
      cur_s[c]  = 0;
      cur_sh[c] = 0;
    end
    apply();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Hardswish reference points, scale 1.0, no offset.
    cur_x  = '{16, -32, -64, 64, 127, -128, 0, 1, -1, 48, -48, 100};
    cur_s  = '{16, 16, 16};
    cur_sh = '{0, 0, 0};
    start();
    check("busy after accept", int'(bsy), ALL);
    check("ready_in low while running", int'(rdy), 0);
    wait_idle();

    // BN saturation, negative offset, ReLU clamp.
    cur_x  = '{100, 24, -24, -100, 0, 24, -3, -128, -1, 5, 127, 7};
    cur_s  = '{64, 16, 16};
    cur_sh = '{0, -8, 0};
    start();
    wait_idle();

    // Per-channel gain selection.
    for (int n = 0; n < N; n++) cur_x[n] = 16;
    cur_s  = '{16, 32, 48};
    cur_sh = '{0, 0, 0};
    start();
    wait_idle();

    // valid_in mid-run and during the drain cycle is dropped with an overrun pulse.
    randomize_frame();
    start();
    @(negedge clk);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("overrun after mid-run request", int'(ovr), ALL);
    @(negedge clk);
    check("overrun clears", int'(ovr), 0);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("overrun after drain request", int'(ovr), ALL);
    check("ready_in back after frame", int'(rdy), ALL);
    @(negedge clk);
    check("overrun clears after drain", int'(ovr), 0);
    check("no repeat valid_out", int'(vo), 0);
    wait_idle();

    // Back-to-back random frames, each started in the previous frame's valid_out cycle.
    randomize_frame();
    start();
    for (int j = 0; j < 5; j++) begin
      wait_vo();
      randomize_frame();
      start();
    end
    wait_idle();
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    randomize_frame();
    start();
    @(negedge clk);
    #2 rst = 1'b1;
    due_q.delete();
    val_q.delete();
    #1 check_reset_state("mid-frame reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    randomize_frame();
    start();
    wait_idle();
    randomize_frame();
    start();
    wait_idle();

    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
